// File: rtl/pfft_div_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
package pfft_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEF_DIVIDEND_WIDTH = 99;
  localparam int DEF_DIVISOR_WIDTH  = 50;

  // Width of an iteration counter that indexes n quotient bits.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pfft_udiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module pfft_udiv_step #(
  parameter int DIVISOR_WIDTH = 50
) (
  input  logic [DIVISOR_WIDTH:0]   rem_in,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   rem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] trial;
  logic [DIVISOR_WIDTH:0] div_ext;
  logic                   fits;

  // The stored remainder is always below the divisor, so its top bit only
  // matters as a safety net: if it were ever set the trial is certainly larger.
  assign trial   = {rem_in[DIVISOR_WIDTH-1:0], bit_in};
  assign div_ext = {1'b0, divisor};
  assign fits    = rem_in[DIVISOR_WIDTH] || (trial >= div_ext);
  assign rem_out = fits ? (trial - div_ext) : trial;
  assign q_bit   = fits;

endmodule

// File: rtl/pfft_udiv_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
module pfft_udiv_seq
  import pfft_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int CW = cnt_width(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIVIDEND_WIDTH - 1);

  div_state_t                state_reg, state_next;
  logic [DIVIDEND_WIDTH-1:0] quot_reg;
  logic [DIVISOR_WIDTH:0]    rem_reg;
  logic [DIVISOR_WIDTH-1:0]  div_reg;
  logic [CW-1:0]             cnt_reg;
  logic                      dbz_reg;
  logic [DIVISOR_WIDTH:0]    rem_step;
  logic                      q_bit;
  logic                      accept;
  logic                      zero_div;

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign accept      = in_valid && in_ready;
  assign zero_div    = (divisor == '0);
  assign quotient    = quot_reg;
  assign remainder   = rem_reg[DIVISOR_WIDTH-1:0];
  assign div_by_zero = dbz_reg;

  // The quotient register doubles as the dividend shifter: MSBs leave as quotient bits enter.
  pfft_udiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .rem_in (rem_reg),
    .bit_in (quot_reg[DIVIDEND_WIDTH-1]),
    .divisor(div_reg),
    .rem_out(rem_step),
    .q_bit  (q_bit)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = zero_div ? DONE : BUSY;
      BUSY:    if (cnt_reg == LAST_STEP) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            div_reg <= divisor;
            rem_reg <= '0;
            cnt_reg <= '0;
            dbz_reg <= zero_div;
            quot_reg <= zero_div ? '1 : dividend;
          end
        end
        BUSY: begin
          quot_reg <= {quot_reg[DIVIDEND_WIDTH-2:0], q_bit};
          rem_reg  <= rem_step;
          cnt_reg  <= cnt_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pfft_udiv_seq.sv
// Scoreboard bench for pfft_udiv_seq: directed cases plus randomized divides vs. a / and % model.
module tb_pfft_udiv_seq;

  localparam int DW = 99;
  localparam int SW = 50;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  pfft_udiv_seq #(
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH (SW)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  bit   hs = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: plain integer division on wide vectors.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [SW-1:0] b, input int acc);
    exp_t e;
    logic [127:0] aa, bb, qq, rr;
    aa = 128'(a);
    bb = 128'(b);
    e.acc = acc;
    if (bb == 0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      qq = aa / bb;
      rr = aa % bb;
      e.q = qq[DW-1:0]; e.r = rr[SW-1:0]; e.dbz = 1'b0; e.lat = DW + 1;
    end
    return e;
  endfunction

  // Monitor: compares every cycle a result is presented, pops on handshake.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (hs) begin
        chk("in_ready_after_handshake", 128'(in_ready), 128'(1));
        hs = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          timeout("unexpected_out_valid");
        end else begin
          mon_e = sb[0];
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
          end
          chk("quotient", 128'(quotient), 128'(mon_e.q));
          chk("remainder", 128'(remainder), 128'(mon_e.r));
          chk("div_by_zero", 128'(div_by_zero), 128'(mon_e.dbz));
          chk("in_ready_low_while_valid", 128'(in_ready), 128'(0));
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            hs = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge ap_clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [SW-1:0] b, input bit hold);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!in_ready && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 400) begin
      timeout("send_wait_in_ready");
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b, cyc));
    $display("issue: dividend=%0h divisor=%0h cycle=%0d", a, b, cyc);
    @(posedge ap_clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 400) timeout("wait_drain");
    @(negedge ap_clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_quotient"}, 128'(quotient), 128'(0));
    chk({tag, "_remainder"}, 128'(remainder), 128'(0));
    chk({tag, "_div_by_zero"}, 128'(div_by_zero), 128'(0));
  endtask

  initial begin
    logic [127:0] prod;
    logic [127:0] ra;
    logic [63:0]  rb;
    int           n;

    repeat (3) @(posedge ap_clk);
    #1;
    check_reset("reset");
    ap_rst_n = 1'b1;
    out_ready = 1'b1;

    send(DW'(100), SW'(7), 1'b0);
    wait_drain();
    prod = 128'h3FFFFFFFFFFFF * 128'h2AAAAAAAAAAAA;
    send(prod[DW-1:0], SW'(50'h2AAAAAAAAAAAA), 1'b0);
    wait_drain();
    send(DW'(12345), SW'(0), 1'b0);
    wait_drain();
    send(DW'(5), SW'(9), 1'b0);
    wait_drain();

    // Backpressure: hold the result for 20 cycles, then a one-cycle accept pulse.
    out_ready = 1'b0;
    send(DW'(1000003), SW'(17), 1'b0);
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 400) timeout("wait_out_valid");
    repeat (20) @(posedge ap_clk);
    #1 out_ready = 1'b1;
    @(posedge ap_clk);
    #1 out_ready = 1'b0;
    @(negedge ap_clk);
    out_ready = 1'b1;
    wait_drain();

    // in_valid held through BUSY/DONE with junk operands must be ignored.
    send({DW{1'b1}}, SW'(3), 1'b1);
    dividend = DW'(777);
    divisor = SW'(0);
    send(DW'(123456789), SW'(1000), 1'b0);
    wait_drain();

    // Reset in the middle of a divide discards the result.
    send({DW{1'b1}}, SW'(3), 1'b0);
    repeat (40) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1;
    check_reset("midreset");
    sb.delete();
    seen = 1'b0;
    hs = 1'b0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    send(DW'(1000), SW'(10), 1'b0);
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      ra = ra >> (29 + $urandom_range(0, 60));
      rb = {$urandom, $urandom};
      rb = rb >> (14 + $urandom_range(0, 50));
      if (i % 7 == 3) rb = '0;
      send(ra[DW-1:0], rb[SW-1:0], 1'b0);
    end
    wait_drain();
    rand_ready = 1'b0;
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
